pkt_gen_flow_sched: RTL and testbench



---
 rtl/pkt_gen_flow_sched_if.sv | 26 ++
 rtl/pkt_gen_flow_sched.sv | 159 +++++++++++++++
 tb/tb_pkt_gen_flow_sched.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pkt_gen_flow_sched_if.sv
// Config write port and packet-request handshake between the flow scheduler
// and the packet builder.
interface pkt_gen_flow_sched_if #(
  parameter int FLOW_CNT_WIDTH = 4,
  parameter int SIZE_WIDTH     = 16,
  parameter int BUCKET_WIDTH   = 32
);
  logic [FLOW_CNT_WIDTH-1:0] cfg_addr_i;
  logic [1:0]                cfg_field_i;
  logic [BUCKET_WIDTH-1:0]   cfg_data_i;
  logic                      cfg_wr_en_i;
  logic                      pkt_valid_o;
  logic                      pkt_ready_i;
  logic [FLOW_CNT_WIDTH-1:0] pkt_flow_o;
  logic [SIZE_WIDTH-1:0]     pkt_size_o;

  modport master (
    input  cfg_addr_i, cfg_field_i, cfg_data_i, cfg_wr_en_i, pkt_ready_i,
    output pkt_valid_o, pkt_flow_o, pkt_size_o
  );

  modport slave (
    output cfg_addr_i, cfg_field_i, cfg_data_i, cfg_wr_en_i, pkt_ready_i,
    input  pkt_valid_o, pkt_flow_o, pkt_size_o
  );
endinterface

// File: rtl/pkt_gen_flow_sched.sv
// Multi-flow token-bucket scheduler: round-robin over eligible flows, one
// (flow, size) request at a time, held stable under backpressure.
module pkt_gen_flow_sched #(
  parameter int FLOW_CNT       = 16,
  parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
  parameter int SIZE_WIDTH     = 16,
  parameter int BUCKET_WIDTH   = 32,
  parameter int TICK_DIV       = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  pkt_gen_flow_sched_if.master bus
);
  localparam int TICK_W = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t                    r_state, w_state_nxt;
  logic [TICK_W-1:0]         r_tick_cnt;
  logic [FLOW_CNT_WIDTH-1:0] r_ptr;
  logic [FLOW_CNT_WIDTH-1:0] r_pkt_flow;
  logic [SIZE_WIDTH-1:0]     r_pkt_size;
  logic                      w_tick;
  logic                      w_addr_ok;
  logic                      w_latch;
  logic                      w_accept;
  logic                      w_found;
  logic [FLOW_CNT_WIDTH-1:0] w_sel;
  logic [FLOW_CNT-1:0]       w_elig;
  logic [SIZE_WIDTH-1:0]     w_size   [FLOW_CNT];
  logic [BUCKET_WIDTH-1:0]   w_bucket [FLOW_CNT];

  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Out-of-range addresses only exist when FLOW_CNT is not a power of two.
  generate
    if (FLOW_CNT == (1 << FLOW_CNT_WIDTH)) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_part
      assign w_addr_ok = ({1'b0, bus.cfg_addr_i} < (FLOW_CNT_WIDTH + 1)'(FLOW_CNT));
    end
  endgenerate

  genvar g;
  generate
    for (g = 0; g < FLOW_CNT; g++) begin : gen_flow
      logic [SIZE_WIDTH-1:0]   r_size;
      logic [BUCKET_WIDTH-1:0] r_rate, r_max, r_bucket;
      logic                    r_en;
      logic                    w_wr, w_dis;
      logic [BUCKET_WIDTH-1:0] w_size_ext, w_debit, w_fill, w_nxt;
      logic [BUCKET_WIDTH:0]   w_sum;

      assign w_wr       = bus.cfg_wr_en_i && w_addr_ok && (bus.cfg_addr_i == FLOW_CNT_WIDTH'(g));
      assign w_dis      = w_wr && (bus.cfg_field_i == 2'd3) && !bus.cfg_data_i[0];
      assign w_size_ext = {{(BUCKET_WIDTH - SIZE_WIDTH){1'b0}}, r_pkt_size};

      // Debit the accepted flow first, then refill on top with a saturating add.
      always_comb begin
        w_debit = r_bucket;
        if (w_accept && (r_pkt_flow == FLOW_CNT_WIDTH'(g)))
          w_debit = (r_bucket >= w_size_ext) ? (r_bucket - w_size_ext) : '0;
        w_sum  = {1'b0, w_debit} + {1'b0, r_rate};
        w_fill = (w_sum > {1'b0, r_max}) ? r_max : w_sum[BUCKET_WIDTH-1:0];
        w_nxt  = w_debit;
        if (w_dis)                 w_nxt = '0;
        else if (w_tick && r_en)   w_nxt = w_fill;
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_size   <= '0;
          r_rate   <= '0;
          r_max    <= '0;
          r_en     <= 1'b0;
          r_bucket <= '0;
        end else begin
          if (w_wr && (bus.cfg_field_i == 2'd0)) r_size <= bus.cfg_data_i[SIZE_WIDTH-1:0];
          if (w_wr && (bus.cfg_field_i == 2'd1)) r_rate <= bus.cfg_data_i;
          if (w_wr && (bus.cfg_field_i == 2'd2)) r_max  <= bus.cfg_data_i;
          if (w_wr && (bus.cfg_field_i == 2'd3)) r_en   <= bus.cfg_data_i[0];
          r_bucket <= w_nxt;
        end
      end

      assign w_elig[g]   = r_en && (r_size != '0) && (r_bucket >= {{(BUCKET_WIDTH - SIZE_WIDTH){1'b0}}, r_size});
      assign w_size[g]   = r_size;
      assign w_bucket[g] = r_bucket;
    end
  endgenerate

  // Round-robin search starting just past the last granted flow.
  always_comb begin
    int                        idx;
    logic [FLOW_CNT_WIDTH-1:0] v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    idx     = 0;
    v_idx   = '0;
    for (int k = 1; k <= FLOW_CNT; k++) begin
      idx   = (int'(r_ptr) + k) % FLOW_CNT;
      v_idx = FLOW_CNT_WIDTH'(idx);
      if (!w_found && w_elig[v_idx]) begin
        w_found = 1'b1;
        w_sel   = v_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_latch     = 1'b1;
          w_state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        if (bus.pkt_ready_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pkt_flow <= '0;
      r_pkt_size <= '0;
      r_ptr      <= FLOW_CNT_WIDTH'(FLOW_CNT - 1);
    end else begin
      if (w_latch) begin
        r_pkt_flow <= w_sel;
        r_pkt_size <= w_size[w_sel];
      end
      if (w_accept) r_ptr <= r_pkt_flow;
    end
  end

  assign bus.pkt_valid_o = (r_state == S_OFFER);
  assign bus.pkt_flow_o  = r_pkt_flow;
  assign bus.pkt_size_o  = r_pkt_size;
endmodule

// File: tb/tb_pkt_gen_flow_sched.sv
// Directed bench for pkt_gen_flow_sched: idle, single-flow pacing, fairness,
// backpressure/saturation, disable mid-offer and asynchronous reset mid-offer.
module tb_pkt_gen_flow_sched;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pkt_gen_flow_sched_if #(.FLOW_CNT_WIDTH(4), .SIZE_WIDTH(16), .BUCKET_WIDTH(32)) bus ();

  pkt_gen_flow_sched #(
    .FLOW_CNT(16), .SIZE_WIDTH(16), .BUCKET_WIDTH(32), .TICK_DIV(1)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int addr, input int field, input int data);
    bus.cfg_addr_i  = 4'(addr);
    bus.cfg_field_i = 2'(field);
    bus.cfg_data_i  = 32'(data);
    bus.cfg_wr_en_i = 1'b1;
    cyc();
    bus.cfg_wr_en_i = 1'b0;
  endtask

  task automatic setup_flow(input int addr, input int size, input int rate, input int mx);
    cfg(addr, 0, size);
    cfg(addr, 1, rate);
    cfg(addr, 2, mx);
    cfg(addr, 3, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.pkt_valid_o && n < 40) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int n;
    int cnt;
    int viol;
    int hits[$];
    int flows[$];
    logic [15:0] exp_flow[6];
    logic [31:0] bsum;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.cfg_addr_i  = '0;
    bus.cfg_field_i = '0;
    bus.cfg_data_i  = '0;
    bus.cfg_wr_en_i = 1'b0;
    bus.pkt_ready_i = 1'b1;
    cyc();
    cyc();
    check("rst_valid", 64'(bus.pkt_valid_o), 64'd0);
    check("rst_flow",  64'(bus.pkt_flow_o),  64'd0);
    check("rst_size",  64'(bus.pkt_size_o),  64'd0);

    // Idle: nothing configured
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.pkt_valid_o) cnt++;
      cyc();
    end
    check("idle_valid_cnt", 64'(cnt), 64'd0);

    // Single flow: 64B, +16 per tick
    do_reset();
    bus.pkt_ready_i = 1'b1;
    setup_flow(0, 64, 16, 1000);
    wait_valid(n);
    check("single_latency", 64'(n), 64'd5);
    check("single_flow", 64'(bus.pkt_flow_o), 64'd0);
    check("single_size", 64'(bus.pkt_size_o), 64'd64);
    hits.delete();
    for (int c = 0; c < 20; c++) begin
      if (bus.pkt_valid_o) hits.push_back(c);
      cyc();
    end
    check("single_hits", 64'(hits.size()), 64'd5);
    for (int k = 1; k < 5; k++)
      if (k < hits.size()) check("single_interval", 64'(hits[k] - hits[k-1]), 64'd4);

    // Fairness between flows 0 and 3
    do_reset();
    bus.pkt_ready_i = 1'b1;
    cfg(0, 0, 64); cfg(0, 1, 64); cfg(0, 2, 4096);
    cfg(3, 0, 64); cfg(3, 1, 64); cfg(3, 2, 4096);
    cfg(0, 3, 1);
    cfg(3, 3, 1);
    flows.delete();
    for (int c = 0; c < 40; c++) begin
      if (bus.pkt_valid_o) flows.push_back(int'(bus.pkt_flow_o));
      cyc();
    end
    exp_flow = '{16'd0, 16'd3, 16'd0, 16'd3, 16'd0, 16'd3};
    for (int k = 0; k < 6; k++) begin
      if (k < flows.size()) check("fair_grant", 64'(flows[k]), 64'(exp_flow[k]));
      else check("fair_grant_missing", 64'(flows.size()), 64'(k + 1));
    end

    // Backpressure and burst saturation
    do_reset();
    bus.pkt_ready_i = 1'b0;
    setup_flow(0, 64, 10, 200);
    wait_valid(n);
    check("bp_valid_up", 64'(bus.pkt_valid_o), 64'd1);
    viol = 0;
    for (int c = 0; c < 100; c++) begin
      if (!bus.pkt_valid_o || bus.pkt_flow_o !== 4'd0 || bus.pkt_size_o !== 16'd64) viol++;
      cyc();
    end
    check("bp_hold_violations", 64'(viol), 64'd0);
    check("bp_bucket_cap", 64'(dut.w_bucket[0]), 64'd200);
    bus.pkt_ready_i = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.pkt_valid_o) cnt++;
      if (c == 5) check("bp_bucket_after", 64'(dut.w_bucket[0]), 64'd58);
      cyc();
    end
    check("bp_burst_cnt", 64'(cnt), 64'd3);

    // Disable during an offer
    do_reset();
    bus.pkt_ready_i = 1'b0;
    setup_flow(0, 64, 16, 1000);
    wait_valid(n);
    cfg(0, 3, 0);
    check("dis_valid_held", 64'(bus.pkt_valid_o), 64'd1);
    check("dis_flow_held",  64'(bus.pkt_flow_o),  64'd0);
    check("dis_size_held",  64'(bus.pkt_size_o),  64'd64);
    bus.pkt_ready_i = 1'b1;
    cyc();
    check("dis_bucket", 64'(dut.w_bucket[0]), 64'd0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.pkt_valid_o) cnt++;
      cyc();
    end
    check("dis_no_more", 64'(cnt), 64'd0);

    // Asynchronous reset during an offer
    do_reset();
    bus.pkt_ready_i = 1'b0;
    setup_flow(0, 64, 16, 1000);
    wait_valid(n);
    check("ar_valid_before", 64'(bus.pkt_valid_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid_drop", 64'(bus.pkt_valid_o), 64'd0);
    bsum = '0;
    for (int i = 0; i < 16; i++) bsum = bsum | dut.w_bucket[i];
    check("ar_buckets_zero", 64'(bsum), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.pkt_ready_i = 1'b1;
    cfg(2, 0, 64); cfg(2, 1, 16); cfg(2, 2, 1000);
    cfg(5, 0, 64); cfg(5, 1, 16); cfg(5, 2, 1000);
    cfg(2, 3, 1);
    cfg(5, 3, 1);
    flows.delete();
    for (int c = 0; c < 30; c++) begin
      if (bus.pkt_valid_o) flows.push_back(int'(bus.pkt_flow_o));
      cyc();
    end
    if (flows.size() >= 2) begin
      check("ar_first_grant",  64'(flows[0]), 64'd2);
      check("ar_second_grant", 64'(flows[1]), 64'd5);
    end else begin
      check("ar_grant_cnt", 64'(flows.size()), 64'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
